// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: access sequencer between decode and reg_stack.
// Accepts operand reads (rd_*) and writebacks (wb_*) over valid/ready handshakes and
// drives reg_stack's single shared port with at most one operation per cycle.
// Reads win over writes. Writebacks go through a one-entry buffer that drains whenever
// no read issues. A read that hits the buffered entry is forwarded from the buffer.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   rd_valid/rd_ready           operand-read request handshake, rd_num1/rd_num2 registers
//   op_valid/op_ready           registered operand handshake to execute, op_a/op_b values
//   wb_valid/wb_ready           writeback handshake, wb_num/wb_val destination and data
//   rs_num1/rs_num2/rs_setnum   reg_stack register numbers (0 when the enable is low)
//   rs_setval                   reg_stack write data (0 when rs_set_enable is low)
//   rs_get_enable/rs_set_enable reg_stack strobes, mutually exclusive
//   rs_out1/rs_out2             reg_stack read data, valid in the cycle after a get
module reg_access_ctrl #(
  parameter int unsigned NIB_SIZE  = 4,
  parameter int unsigned WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_valid,
  output logic                 rd_ready,
  input  logic [NIB_SIZE-1:0]  rd_num1,
  input  logic [NIB_SIZE-1:0]  rd_num2,
  output logic                 op_valid,
  input  logic                 op_ready,
  output logic [WORD_SIZE-1:0] op_a,
  output logic [WORD_SIZE-1:0] op_b,
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  logic [NIB_SIZE-1:0]  wb_num,
  input  logic [WORD_SIZE-1:0] wb_val,
  output logic [NIB_SIZE-1:0]  rs_num1,
  output logic [NIB_SIZE-1:0]  rs_num2,
  output logic [NIB_SIZE-1:0]  rs_setnum,
  output logic [WORD_SIZE-1:0] rs_setval,
  output logic                 rs_get_enable,
  output logic                 rs_set_enable,
  input  logic [WORD_SIZE-1:0] rs_out1,
  input  logic [WORD_SIZE-1:0] rs_out2
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold
  } state_e;

  state_e state_q, state_d;

  logic                 wb_pend_q;
  logic [NIB_SIZE-1:0]  wb_pnum_q;
  logic [WORD_SIZE-1:0] wb_pval_q;
  logic                 fwd1_q, fwd2_q;
  logic [WORD_SIZE-1:0] fwd_val_q;
  logic [WORD_SIZE-1:0] op_a_q, op_b_q;

  logic read_issue;
  logic drain;
  logic wb_load;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (rd_valid) state_d = StFetch;
      StFetch: state_d = StHold;
      StHold:  if (op_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    read_issue = (state_q == StIdle) && rd_valid && !reset;
    // The buffer drains in every cycle the port is not taken by a read.
    drain      = wb_pend_q && !read_issue;
    rd_ready   = !reset && (state_q == StIdle);
    wb_ready   = !reset && (!wb_pend_q || drain);
    wb_load    = wb_valid && wb_ready;
    op_valid   = (state_q == StHold);

    rs_get_enable = read_issue;
    rs_num1       = read_issue ? rd_num1 : '0;
    rs_num2       = read_issue ? rd_num2 : '0;
    rs_set_enable = drain;
    rs_setnum     = drain ? wb_pnum_q : '0;
    rs_setval     = drain ? wb_pval_q : '0;

    op_a = op_a_q;
    op_b = op_b_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      wb_pend_q <= 1'b0;
      wb_pnum_q <= '0;
      wb_pval_q <= '0;
      fwd1_q    <= 1'b0;
      fwd2_q    <= 1'b0;
      fwd_val_q <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
    end else begin
      state_q <= state_d;

      // Forward only from an entry buffered before this cycle; a same-cycle writeback
      // is ordered after the read.
      if (read_issue) begin
        fwd1_q    <= wb_pend_q && (wb_pnum_q == rd_num1);
        fwd2_q    <= wb_pend_q && (wb_pnum_q == rd_num2);
        fwd_val_q <= wb_pval_q;
      end

      if (state_q == StFetch) begin
        op_a_q <= fwd1_q ? fwd_val_q : rs_out1;
        op_b_q <= fwd2_q ? fwd_val_q : rs_out2;
        fwd1_q <= 1'b0;
        fwd2_q <= 1'b0;
      end

      if (wb_load) begin
        wb_pend_q <= 1'b1;
        wb_pnum_q <= wb_num;
        wb_pval_q <= wb_val;
      end else if (drain) begin
        wb_pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Testbench for reg_access_ctrl: behavioural reg_stack, architectural register-file
// reference model, scoreboard queue of expected operand pairs popped by a monitor.
module tb_reg_access_ctrl;

  localparam int unsigned NIB_SIZE  = 4;
  localparam int unsigned WORD_SIZE = 16;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 rd_valid = 1'b0;
  logic                 rd_ready;
  logic [NIB_SIZE-1:0]  rd_num1 = '0;
  logic [NIB_SIZE-1:0]  rd_num2 = '0;
  logic                 op_valid;
  logic                 op_ready = 1'b1;
  logic [WORD_SIZE-1:0] op_a, op_b;
  logic                 wb_valid = 1'b0;
  logic                 wb_ready;
  logic [NIB_SIZE-1:0]  wb_num = '0;
  logic [WORD_SIZE-1:0] wb_val = '0;
  logic [NIB_SIZE-1:0]  rs_num1, rs_num2, rs_setnum;
  logic [WORD_SIZE-1:0] rs_setval;
  logic                 rs_get_enable, rs_set_enable;
  logic [WORD_SIZE-1:0] rs_out1 = '0;
  logic [WORD_SIZE-1:0] rs_out2 = '0;

  reg_access_ctrl #(
    .NIB_SIZE (NIB_SIZE),
    .WORD_SIZE(WORD_SIZE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_num1      (rd_num1),
    .rd_num2      (rd_num2),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_num       (wb_num),
    .wb_val       (wb_val),
    .rs_num1      (rs_num1),
    .rs_num2      (rs_num2),
    .rs_setnum    (rs_setnum),
    .rs_setval    (rs_setval),
    .rs_get_enable(rs_get_enable),
    .rs_set_enable(rs_set_enable),
    .rs_out1      (rs_out1),
    .rs_out2      (rs_out2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reg_stack environment: registered reads, get has priority over set, no reset.
  logic [WORD_SIZE-1:0] mem [16] = '{default: '0};
  always @(posedge clk) begin
    if (rs_get_enable) begin
      rs_out1 <= mem[rs_num1];
      rs_out2 <= mem[rs_num2];
    end else if (rs_set_enable) begin
      mem[rs_setnum] <= rs_setval;
    end
  end

  // Reference model: architectural register values as seen by the next read.
  typedef struct {
    logic [WORD_SIZE-1:0] a;
    logic [WORD_SIZE-1:0] b;
    int                   acc_cyc;
  } exp_t;

  logic [WORD_SIZE-1:0] arch [16] = '{default: '0};
  exp_t                 exp_q[$];

  int unsigned tests = 0;
  int unsigned fails = 0;
  bit          opr = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus. Acceptance is resolved from the handshake; the model sees a
  // read before any writeback accepted in the same cycle.
  task automatic drive(input bit rv, input logic [3:0] n1, input logic [3:0] n2,
                       input bit wv, input logic [3:0] wn, input logic [15:0] wval,
                       input bit commit, output bit racc, output bit wacc);
    exp_t e;
    @(negedge clk);
    rd_valid = rv;
    rd_num1  = n1;
    rd_num2  = n2;
    wb_valid = wv;
    wb_num   = wn;
    wb_val   = wval;
    op_ready = opr;
    #1;
    racc = rv && rd_ready;
    wacc = wv && wb_ready;
    if (racc) begin
      e.a       = arch[n1];
      e.b       = arch[n2];
      e.acc_cyc = cyc;
      exp_q.push_back(e);
    end
    if (wacc && commit) arch[wn] = wval;
  endtask

  task automatic idle(input int n);
    bit r, w;
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 1, r, w);
  endtask

  task automatic wr(input logic [3:0] wn, input logic [15:0] wval, output bit wacc);
    bit r;
    drive(0, 0, 0, 1, wn, wval, 1, r, wacc);
  endtask

  task automatic rd(input logic [3:0] n1, input logic [3:0] n2, output bit racc);
    bit w;
    drive(1, n1, n2, 0, 0, 0, 1, racc, w);
  endtask

  // Monitor: port invariants each cycle, operand latency, scoreboard compare.
  bit prev_valid = 1'b0;
  always @(negedge clk) begin
    #3;
    if (!reset) begin
      chk("get_set_exclusive", {31'd0, rs_get_enable && rs_set_enable}, 32'd0);
      if (!rs_get_enable) chk("rs_num_idle_zero", {24'd0, rs_num1, rs_num2}, 32'd0);
      if (!rs_set_enable) chk("rs_set_idle_zero", {12'd0, rs_setnum, rs_setval}, 32'd0);
      if (op_valid && !prev_valid) begin
        if (exp_q.size() == 0) chk("op_valid_unexpected", 32'd1, 32'd0);
        else chk("op_latency", cyc - exp_q[0].acc_cyc, 32'd2);
      end
      if (op_valid && op_ready) begin
        if (exp_q.size() == 0) begin
          chk("op_pop_empty", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("op_a", {16'd0, op_a}, {16'd0, e.a});
          chk("op_b", {16'd0, op_b}, {16'd0, e.b});
        end
      end
    end
    prev_valid = op_valid;
  end

  initial begin
    bit ra, wa;
    bit rpend, wpend;
    logic [3:0] rn1, rn2, wn;
    logic [15:0] wv;

    // Reset state.
    repeat (2) @(negedge clk);
    #2;
    chk("rst_rd_ready", {31'd0, rd_ready}, 32'd0);
    chk("rst_wb_ready", {31'd0, wb_ready}, 32'd0);
    chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
    chk("rst_op_ab", {op_a, op_b}, 32'd0);
    chk("rst_rs_en", {30'd0, rs_get_enable, rs_set_enable}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Write then read the same register from both ports.
    wr(4'd3, 16'h1234, wa);
    chk("t1_wb_acc", {31'd0, wa}, 32'd1);
    idle(2);
    rd(4'd3, 4'd3, ra);
    chk("t1_rd_acc", {31'd0, ra}, 32'd1);
    idle(4);
    wr(4'd2, 16'h0007, wa);
    wr(4'd4, 16'h0011, wa);
    idle(2);

    // Buffered write hit by the next read: read issues first, buffer drains in FETCH.
    wr(4'd5, 16'hBEEF, wa);
    rd(4'd5, 4'd2, ra);
    chk("t2_rd_acc", {31'd0, ra}, 32'd1);
    idle(1);
    #1;
    chk("t2_fetch_set_en", {31'd0, rs_set_enable}, 32'd1);
    chk("t2_fetch_setnum", {28'd0, rs_setnum}, 32'd5);
    chk("t2_fetch_setval", {16'd0, rs_setval}, 32'h0000BEEF);
    idle(3);

    // Same-cycle read and write: the read sees the old value.
    drive(1, 4'd4, 4'd4, 1, 4'd4, 16'h00AA, 1, ra, wa);
    chk("t3_rd_acc", {31'd0, ra}, 32'd1);
    chk("t3_wb_acc", {31'd0, wa}, 32'd1);
    idle(3);
    rd(4'd4, 4'd4, ra);
    idle(3);

    // Back-pressure in HOLD: operands stable, no new read, writes still drain.
    opr = 1'b0;
    rd(4'd3, 4'd5, ra);
    idle(1);
    wr(4'd6, 16'h0066, wa);
    chk("t4_wb_acc_hold", {31'd0, wa}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      #1;
      chk("t4_hold_valid", {31'd0, op_valid}, 32'd1);
      chk("t4_hold_op", {op_a, op_b}, 32'h1234BEEF);
      chk("t4_hold_rd_ready", {31'd0, rd_ready}, 32'd0);
      if (i == 0) chk("t4_hold_drain", {27'd0, rs_set_enable, rs_setnum}, 32'h16);
    end
    opr = 1'b1;
    idle(3);
    rd(4'd6, 4'd6, ra);
    idle(3);

    // Reset in FETCH with a buffered write: everything dropped.
    drive(1, 4'd7, 4'd7, 1, 4'd7, 16'h5555, 0, ra, wa);
    chk("t5_wb_acc", {31'd0, wa}, 32'd1);
    @(negedge clk);
    #1;
    reset    = 1'b1;
    rd_valid = 1'b0;
    wb_valid = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_rst_op_valid", {31'd0, op_valid}, 32'd0);
    chk("t5_rst_op_ab", {op_a, op_b}, 32'd0);
    chk("t5_rst_readies", {30'd0, rd_ready, wb_ready}, 32'd0);
    chk("t5_rst_rs_en", {30'd0, rs_get_enable, rs_set_enable}, 32'd0);
    chk("t5_rst_rs_data", {12'd0, rs_setnum, rs_setval}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    #1;
    chk("t5_post_op_valid", {31'd0, op_valid}, 32'd0);
    rd(4'd7, 4'd7, ra);
    idle(4);

    // Back-to-back writes: one drain per cycle, buffer never blocks.
    for (int k = 1; k <= 3; k++) begin
      wr(k[3:0], k[15:0], wa);
      chk("t6_wb_acc", {31'd0, wa}, 32'd1);
      if (k > 1) begin
        #1;
        chk("t6_drain", {27'd0, rs_set_enable, rs_setnum}, 32'h10 | (k - 1));
      end
    end
    idle(1);
    #1;
    chk("t6_drain_last", {27'd0, rs_set_enable, rs_setnum}, 32'h13);
    idle(2);

    // Randomized traffic with held requests until accepted.
    rpend = 1'b0;
    wpend = 1'b0;
    rn1 = '0; rn2 = '0; wn = '0; wv = '0;
    for (int it = 0; it < 600; it++) begin
      if (!rpend && $urandom_range(0, 2) == 0) begin
        rpend = 1'b1;
        rn1 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
        rn2 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      end
      if (!wpend && $urandom_range(0, 1) == 0) begin
        wpend = 1'b1;
        wn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
        wv = 16'($urandom);
      end
      opr = ($urandom_range(0, 3) != 0);
      drive(rpend, rn1, rn2, wpend, wn, wv, 1, ra, wa);
      if (ra) rpend = 1'b0;
      if (wa) wpend = 1'b0;
    end

    opr = 1'b1;
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) idle(1);
    chk("final_queue_empty", exp_q.size(), 32'd0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_access_ctrl.md
# reg_access_ctrl

Access sequencer between the decode stage and `reg_stack`. It accepts operand-read requests and writeback requests through valid/ready handshakes and drives `reg_stack`'s single shared port, one operation per cycle. Reads have priority over writes, matching `reg_stack`'s get-over-set priority. A one-entry write buffer absorbs writebacks, and a read that hits the buffered write is forwarded. Operands go to the execute stage as a registered valid/ready pair.

## Interface
- `NIB_SIZE`, 4, register-number width (from `parameters.v`)
- `WORD_SIZE`, 16, data width (from `parameters.v`)

- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `rd_valid`  in  1  decode presents an operand-read request
- `rd_ready`  out  1  request accepted this cycle when both are high
- `rd_num1`, `rd_num2`  in  NIB_SIZE  registers to read
- `op_valid`  out  1  `op_a`/`op_b` valid
- `op_ready`  in  1  execute consumes operands
- `op_a`, `op_b`  out  WORD_SIZE  operand values for `rd_num1`/`rd_num2`
- `wb_valid`  in  1  writeback request
- `wb_ready`  out  1  write buffer can accept
- `wb_num`  in  NIB_SIZE  destination register
- `wb_val`  in  WORD_SIZE  value to write
- `rs_num1`, `rs_num2`, `rs_setnum`  out  NIB_SIZE  to `reg_stack` `num1`/`num2`/`setnum`
- `rs_setval`  out  WORD_SIZE  to `reg_stack` `setval`
- `rs_get_enable`, `rs_set_enable`  out  1  to `reg_stack`; never both high
- `rs_out1`, `rs_out2`  in  WORD_SIZE  from `reg_stack` `out1`/`out2`

## Operation
- FSM states:
  - IDLE: `rd_ready`=1.
  - FETCH: `reg_stack` outputs are valid.
  - HOLD: `op_valid`=1.
- FSM transitions:
  - IDLE→FETCH on `rd_valid`.
  - FETCH→HOLD unconditionally.
  - HOLD→IDLE on `op_ready`.
- Read issue, in IDLE with `rd_valid`=1:
  - `rs_get_enable`=1 combinationally.
  - `rs_num1`=`rd_num1`, `rs_num2`=`rd_num2`.
  - `rs_set_enable`=0.
- Forwarding: at read issue, if the buffer is pending and `wb_pnum`==`rd_num1`, set `fwd1` and latch `fwd_val` = buffered value. The same applies for `fwd2` with `rd_num2`. Both flags may be set.
- Capture, at the end of FETCH:
  - `op_a` = `fwd1` ? `fwd_val` : `rs_out1`.
  - `op_b` = `fwd2` ? `fwd_val` : `rs_out2`.
  - `fwd1`/`fwd2` are then cleared.
- Write buffer: one entry (`wb_pend`, `wb_pnum`, `wb_pval`).
  - Drain: `rs_set_enable`=1 with `rs_setnum`/`rs_setval` from the buffer in any cycle where `wb_pend`=1 and no read issues.
  - `wb_ready` = !`wb_pend` || drain-this-cycle.
  - Load on `wb_valid && wb_ready`.
- Ordering: a write accepted in the same cycle as a read issue is ordered after that read. It is not forwarded, and the read sees the old value.
- `rs_*` data outputs are 0 when their enable is low.
- HOLD: `op_a`/`op_b` are stable while `op_valid && !op_ready`.

## Timing
- Reset asserted, asynchronously:
  - State → IDLE.
  - `op_valid`=0, `op_a`=`op_b`=0.
  - `wb_pend`=0; a pending write is discarded.
  - `fwd1`=`fwd2`=0.
  - All `rs_*` outputs 0.
  - `rd_ready`=0 and `wb_ready`=0 while `reset` is high.
- Read accepted in cycle T:
  - `get_enable` is high in T.
  - FETCH in T+1.
  - `op_valid` high from T+2.
  - Minimum read-to-read spacing is 3 cycles (with `op_ready` held high).
- Write accepted in cycle T with no read in T+1: `reg_stack` is written at the end of T+1.
- A continuous read stream starves drain only in IDLE issue cycles. FETCH and HOLD cycles always drain.
- Reset during FETCH/HOLD: operands are lost and `op_valid` stays 0 after release.

## Test plan
- Reset, then write r3=0x1234. Idle 2 cycles, then read (3,3) → `op_a`=`op_b`=0x1234 at T+2.
- Write r5=0xBEEF, then read (5,2) in the next cycle (r2=0x0007) → read issues first and forwards: `op_a`=0xBEEF, `op_b`=0x0007. `rs_set_enable` fires in the FETCH cycle.
- Same-cycle `rd_valid` (4,4) and `wb_valid` r4=0x00AA, with r4 previously 0x0011 → `op_a`=`op_b`=0x0011. A later read returns 0x00AA.
- Hold `op_ready`=0 for 5 cycles in HOLD → `op_a`/`op_b` are stable, `rd_ready`=0, and the pending write still drains.
- With a buffered write pending and state FETCH, assert `reset` mid-cycle → all outputs 0 immediately. A read of that register after release returns its pre-write value.
- Back-to-back writes r1=1, r2=2, r3=3 with no reads → one `set_enable` per cycle and `wb_ready` stays high. `get_enable` and `set_enable` are never high together (asserted throughout).
